// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver.
// Glyph codes, segment patterns and the hex glyph table.
package seven_seg_pkg;

  localparam logic [4:0] CODE_H     = 5'h10;
  localparam logic [4:0] CODE_BLANK = 5'h11;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_H   = 7'h09;

  // Active-low patterns, bit order g..a, for codes 0..F
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational glyph decoder: 5-bit code to active-low segments.
// Codes 0x00-0x0F hex, 0x10 'H', everything else blank.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_OFF;
    unique case (1'b1)
      !code[4]:        seg_n = GLYPH[code[3:0]];
      code == CODE_H:  seg_n = SEG_H;
      default:         seg_n = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed common-anode 7-segment driver with double buffer and LZ blanking.
// Optional blink feature enabled by defining SEVSEG_BLINK_EN.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [5*NUM_DIGITS-1:0] codes_in,
  input  logic                    lz_suppress,
`ifdef SEVSEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_start,
  output logic                    pending
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [PW:0]   BLANK_LIM = (PW + 1)'(BLANK_CYCLES);

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [4:0]    disp     [NUM_DIGITS];
  logic [4:0]    pend_buf [NUM_DIGITS];

  logic                  slot_end;
  logic                  frame_edge;
  logic                  guard;
  logic [NUM_DIGITS-1:0] supp;
  logic                  blink_off;
  logic [4:0]            code_mux;
  logic [6:0]            seg_dec;

  assign slot_end   = (presc == PRESC_MAX);
  assign frame_edge = (presc == '0) && (idx == '0);
  assign guard      = ({1'b0, presc} < BLANK_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (slot_end) begin
      presc <= '0;
      idx   <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Transfer and capture can share an edge: old pending data moves, new data stays pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        disp[i]     <= CODE_BLANK;
        pend_buf[i] <= CODE_BLANK;
      end
      pending <= 1'b0;
    end else begin
      if (frame_edge && pending) begin
        for (int i = 0; i < NUM_DIGITS; i++)
          disp[i] <= pend_buf[i];
      end
      if (load) begin
        for (int i = 0; i < NUM_DIGITS; i++)
          pend_buf[i] <= codes_in[5*i +: 5];
      end
      if (load)
        pending <= 1'b1;
      else if (frame_edge)
        pending <= 1'b0;
    end
  end

  always_comb begin
    logic higher_lz;
    higher_lz = 1'b1;
    supp      = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      supp[i]   = lz_suppress && (disp[i] == 5'h00) && higher_lz;
      higher_lz = higher_lz &&
                  ((disp[i] == 5'h00) || (disp[i] >= CODE_BLANK));
    end
  end

`ifdef SEVSEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_cnt;
  logic          blink_on;

  // Counting completed frames makes the phase flip exactly at a frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (slot_end && (idx == IDX_MAX)) begin
      if (frame_cnt == FRAME_MAX) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign blink_off = !blink_on && blink_mask[idx];
`else
  assign blink_off = 1'b0;
`endif

  assign code_mux = (supp[idx] || blink_off) ? CODE_BLANK : disp[idx];

  seven_seg_decode u_decode (
    .code  (code_mux),
    .seg_n (seg_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n       <= SEG_OFF;
      an_n        <= '1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_edge;
      if (guard) begin
        seg_n <= SEG_OFF;
        an_n  <= '1;
      end else begin
        seg_n <= seg_dec;
        an_n  <= ~(NUM_DIGITS'(1) << idx);
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed self-checking bench for seven_seg_scan (4 digits, 8-clock slots).
// Build with SEVSEG_BLINK_EN to also exercise the blink path.
module tb_seven_seg_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [19:0] codes_in = '0;
  logic        lz_suppress = 1'b0;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_start;
  logic        pending;
`ifdef SEVSEG_BLINK_EN
  logic [3:0]  blink_mask = 4'b0000;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  seven_seg_scan #(
    .NUM_DIGITS   (4),
    .PRESCALE     (8),
    .BLANK_CYCLES (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .codes_in    (codes_in),
    .lz_suppress (lz_suppress),
`ifdef SEVSEG_BLINK_EN
    .blink_mask  (blink_mask),
`endif
    .seg_n       (seg_n),
    .an_n        (an_n),
    .frame_start (frame_start),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Outputs after edge (f*32 + i*8 + p + 1) reflect frame f, digit i, prescale p
  task automatic go(input int f, input int i, input int p);
    int tgt;
    tgt = f*32 + i*8 + p + 1;
    if (cyc > tgt) begin
      errors++;
      $display("FAIL sequencing: cycle %0d already past %0d", cyc, tgt);
    end
    while (cyc < tgt) tick();
  endtask

  task automatic dig(input string tag, input int f, input int i,
                     input logic [6:0] exp);
    logic [3:0] ea;
    go(f, i, 2);
    ea = ~(4'b0001 << i);
    chk({tag, "_seg"}, seg_n, exp);
    chk({tag, "_an"}, an_n, ea);
  endtask

  task automatic seg_only(input string tag, input int f, input int i,
                          input logic [6:0] exp);
    go(f, i, 2);
    chk(tag, seg_n, exp);
  endtask

  initial begin
    logic [3:0] ea;
    logic [6:0] e0;
    int         lows;

    #12;
    chk("rst_seg", seg_n, 7'h7F);
    chk("rst_an", an_n, 4'hF);
    chk("rst_fs", frame_start, 1'b0);
    chk("rst_pend", pending, 1'b0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;

    // Frame 0: blank display, scan order and guard; a load lands mid-frame
    lows = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      ea = (((k-1) % 8) < 2) ? 4'hF : ~(4'b0001 << ((k-1) / 8));
      if (an_n != 4'hF) lows++;
      chk("f0_an", an_n, ea);
      chk("f0_seg", seg_n, 7'h7F);
      chk("f0_fs", frame_start, k == 1);
      if (k == 10) begin
        load = 1'b1;
        codes_in = {5'd3, 5'd2, 5'd1, 5'd0};
      end
      if (k == 11) load = 1'b0;
      if (k == 12) chk("mid_pend", pending, 1'b1);
    end
    chk("f0_lows", lows, 24);

    go(1, 0, 0);
    chk("f1_fs", frame_start, 1'b1);
    chk("f1_pend", pending, 1'b0);
    dig("f1_d0", 1, 0, 7'h40);
    dig("f1_d1", 1, 1, 7'h79);
    dig("f1_d2", 1, 2, 7'h24);
    dig("f1_d3", 1, 3, 7'h30);

    go(1, 3, 3);
    load = 1'b1;
    codes_in = {5'd0, 5'd0, 5'd7, 5'd0};
    lz_suppress = 1'b1;
    tick();
    load = 1'b0;
    dig("lz_d0", 2, 0, 7'h40);
    dig("lz_d1", 2, 1, 7'h78);
    seg_only("lz_d2", 2, 2, 7'h7F);
    seg_only("lz_d3", 2, 3, 7'h7F);
    lz_suppress = 1'b0;
    dig("nolz_d2", 3, 2, 7'h40);
    dig("nolz_d3", 3, 3, 7'h40);

    go(3, 3, 3);
    load = 1'b1;
    codes_in = {5'h1F, 5'h11, 5'h10, 5'h08};
    tick();
    load = 1'b0;
    dig("c08", 4, 0, 7'h00);
    dig("c10", 4, 1, 7'h09);
    go(4, 2, 0);
    chk("g0_an", an_n, 4'hF);
    chk("g0_seg", seg_n, 7'h7F);
    go(4, 2, 1);
    chk("g1_an", an_n, 4'hF);
    chk("g1_seg", seg_n, 7'h7F);
    dig("c11", 4, 2, 7'h7F);
    dig("c1f", 4, 3, 7'h7F);

    // Load X mid-frame, then load Y exactly on the frame boundary
    go(4, 3, 3);
    load = 1'b1;
    codes_in = {5'h5, 5'h6, 5'h7, 5'h9};
    tick();
    load = 1'b0;
    go(4, 3, 7);
    load = 1'b1;
    codes_in = {5'hE, 5'hF, 5'hA, 5'hB};
    tick();
    load = 1'b0;
    chk("co_fs", frame_start, 1'b1);
    chk("co_pend", pending, 1'b1);
    dig("x_d0", 5, 0, 7'h10);
    dig("x_d1", 5, 1, 7'h78);
    dig("x_d2", 5, 2, 7'h02);
    dig("x_d3", 5, 3, 7'h12);
    chk("x_pend", pending, 1'b1);
    go(6, 0, 0);
    chk("y_pend", pending, 1'b0);
    dig("y_d0", 6, 0, 7'h03);
    dig("y_d1", 6, 1, 7'h08);
    dig("y_d2", 6, 2, 7'h0E);
    dig("y_d3", 6, 3, 7'h06);

    go(6, 3, 3);
    load = 1'b1;
    codes_in = {5'h1, 5'h1, 5'h1, 5'h1};
    tick();
    codes_in = {5'hC, 5'hD, 5'h4, 5'h2};
    tick();
    load = 1'b0;
    dig("b2b_d0", 7, 0, 7'h24);
    dig("b2b_d1", 7, 1, 7'h19);
    dig("b2b_d2", 7, 2, 7'h21);
    dig("b2b_d3", 7, 3, 7'h46);

    // Asynchronous reset mid-slot with data still pending
    go(7, 3, 3);
    load = 1'b1;
    codes_in = {5'h8, 5'h8, 5'h8, 5'h8};
    tick();
    load = 1'b0;
    chk("pre_rst_pend", pending, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_seg", seg_n, 7'h7F);
    chk("arst_an", an_n, 4'hF);
    chk("arst_fs", frame_start, 1'b0);
    chk("arst_pend", pending, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
`ifdef SEVSEG_BLINK_EN
    blink_mask = 4'b0001;
`endif
    go(0, 0, 0);
    chk("r_fs", frame_start, 1'b1);
    dig("r_d0", 0, 0, 7'h7F);
    dig("r_f1d0", 1, 0, 7'h7F);

    go(1, 0, 3);
    load = 1'b1;
    codes_in = {5'h0, 5'h0, 5'h0, 5'h8};
    tick();
    load = 1'b0;
    for (int f = 2; f <= 7; f++) begin
`ifdef SEVSEG_BLINK_EN
      e0 = ((f / 2) % 2 == 1) ? 7'h7F : 7'h00;
`else
      e0 = 7'h00;
`endif
      dig("blk_d0", f, 0, e0);
      dig("blk_d1", f, 1, 7'h40);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
